// File: rtl/flash_bus_arbiter.sv
// Two-master arbiter for the shared flash bus slave: round-robin or fixed priority,
// one registered transaction at a time, with a timeout that forces an error completion.
module flash_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 255,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    input  logic              m0_select_i,
    input  logic              m0_we_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    input  logic              m1_select_i,
    input  logic              m1_we_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_data_o,
    output logic              s_select_o,
    output logic              s_we_o,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_ack_i
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic              owner;
    logic              last_owner;
    logic              aborted;
    logic [TW-1:0]     timer;
    logic              grant_m1;
    logic              owner_sel;
    logic              finish;
    logic              deliver;
    logic [DATA_W-1:0] result;

    always_comb begin
        grant_m1 = m1_select_i;
        if (m0_select_i && m1_select_i)
            grant_m1 = (FIXED_PRIO != 0) ? 1'b1 : ~last_owner;
    end

    assign owner_sel = owner ? m1_select_i : m0_select_i;
    assign finish    = s_ack_i || (timer == TW'(TIMEOUT - 1));
    // A master that let go of its request mid-transaction gets neither data nor ack.
    assign deliver   = ~aborted & owner_sel;
    assign result    = s_ack_i ? s_data_i : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            aborted    <= 1'b0;
            timer      <= '0;
            s_addr_o   <= '0;
            s_data_o   <= '0;
            s_select_o <= 1'b0;
            s_we_o     <= 1'b0;
            m0_data_o  <= '0;
            m1_data_o  <= '0;
            m0_ack_o   <= 1'b0;
            m1_ack_o   <= 1'b0;
            m0_err_o   <= 1'b0;
            m1_err_o   <= 1'b0;
        end else begin
            m0_ack_o <= 1'b0;
            m1_ack_o <= 1'b0;
            m0_err_o <= 1'b0;
            m1_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_select_i || m1_select_i) begin
                        owner      <= grant_m1;
                        s_addr_o   <= grant_m1 ? m1_addr_i : m0_addr_i;
                        s_data_o   <= grant_m1 ? m1_data_i : m0_data_i;
                        s_we_o     <= grant_m1 ? m1_we_i : m0_we_i;
                        s_select_o <= 1'b1;
                        timer      <= '0;
                        aborted    <= 1'b0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    timer <= timer + TW'(1);
                    if (!owner_sel)
                        aborted <= 1'b1;
                    if (finish) begin
                        s_select_o <= 1'b0;
                        s_we_o     <= 1'b0;
                        state      <= DONE;
                        if (deliver) begin
                            if (owner) begin
                                m1_data_o <= result;
                                m1_ack_o  <= 1'b1;
                                m1_err_o  <= ~s_ack_i;
                            end else begin
                                m0_data_o <= result;
                                m0_ack_o  <= 1'b1;
                                m0_err_o  <= ~s_ack_i;
                            end
                        end
                    end
                end
                DONE: begin
                    last_owner <= owner;
                    timer      <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Directed bench for flash_bus_arbiter: a round-robin instance driven from a vector table,
// plus a fixed-priority instance and hand sequences for reset, abort and timeout corners.
module tb_flash_bus_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_sel, m0_we, m1_sel, m1_we;

    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, s_rdata;
    logic        m0_ack, m0_err, m1_ack, m1_err, s_sel, s_we, s_ack;

    logic [31:0] f_m0_rdata, f_m1_rdata, f_s_addr, f_s_wdata, f_s_rdata;
    logic        f_m0_ack, f_m0_err, f_m1_ack, f_m1_err, f_s_sel, f_s_we, f_s_ack;

    flash_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .m0_addr_i(m0_addr), .m0_data_i(m0_wdata), .m0_select_i(m0_sel), .m0_we_i(m0_we),
        .m0_data_o(m0_rdata), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_addr_i(m1_addr), .m1_data_i(m1_wdata), .m1_select_i(m1_sel), .m1_we_i(m1_we),
        .m1_data_o(m1_rdata), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_addr_o(s_addr), .s_data_o(s_wdata), .s_select_o(s_sel), .s_we_o(s_we),
        .s_data_i(s_rdata), .s_ack_i(s_ack)
    );

    flash_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_addr_i(m0_addr), .m0_data_i(m0_wdata), .m0_select_i(m0_sel), .m0_we_i(m0_we),
        .m0_data_o(f_m0_rdata), .m0_ack_o(f_m0_ack), .m0_err_o(f_m0_err),
        .m1_addr_i(m1_addr), .m1_data_i(m1_wdata), .m1_select_i(m1_sel), .m1_we_i(m1_we),
        .m1_data_o(f_m1_rdata), .m1_ack_o(f_m1_ack), .m1_err_o(f_m1_err),
        .s_addr_o(f_s_addr), .s_data_o(f_s_wdata), .s_select_o(f_s_sel), .s_we_o(f_s_we),
        .s_data_i(f_s_rdata), .s_ack_i(f_s_ack)
    );

    // delay: BUSY cycle index on which the slave acks; negative means it never acks.
    typedef struct {
        logic        r0;
        logic        r1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        we0;
        logic        we1;
        int          delay;
        logic [31:0] sdata;
        logic        exp_m1;
    } vec_t;

    vec_t        vecs[8];
    int          total = 0;
    int          bad = 0;
    logic [31:0] last_data[2];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        logic        got;
        logic        stable;
        int          k;
        int          hi;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_hi;
        exp_addr = v.exp_m1 ? v.a1 : v.a0;
        exp_err  = (v.delay < 0);
        exp_data = exp_err ? 32'h0 : v.sdata;
        exp_hi   = exp_err ? 8 : v.delay + 1;

        @(negedge clk);
        m0_sel = v.r0;  m1_sel = v.r1;
        m0_addr = v.a0; m1_addr = v.a1;
        m0_we = v.we0;  m1_we = v.we1;
        m0_wdata = v.a0 ^ 32'hA5A5_0000;
        m1_wdata = v.a1 ^ 32'hA5A5_0000;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = s_sel;
        end
        check_output($sformatf("v%0d grant", idx), 32'(got), 32'd1);
        if (!got) return;
        check_output($sformatf("v%0d s_addr", idx), s_addr, exp_addr);
        check_output($sformatf("v%0d s_we", idx), 32'(s_we), 32'(v.exp_m1 ? v.we1 : v.we0));
        check_output($sformatf("v%0d s_wdata", idx), s_wdata, exp_addr ^ 32'hA5A5_0000);

        m0_addr = 32'hDEAD_0000;
        m1_addr = 32'hDEAD_0001;
        k = 0; hi = 0; stable = 1'b1; got = 1'b0;
        while (!got && k < 30) begin
            if (s_sel) hi++;
            if (s_sel && s_addr !== exp_addr) stable = 1'b0;
            s_ack   = (k == v.delay);
            s_rdata = v.sdata;
            @(negedge clk);
            k++;
            got = m0_ack | m1_ack;
        end
        s_ack = 1'b0;

        check_output($sformatf("v%0d m0_ack", idx), 32'(m0_ack), 32'(!v.exp_m1));
        check_output($sformatf("v%0d m1_ack", idx), 32'(m1_ack), 32'(v.exp_m1));
        check_output($sformatf("v%0d m0_err", idx), 32'(m0_err), 32'(!v.exp_m1 && exp_err));
        check_output($sformatf("v%0d m1_err", idx), 32'(m1_err), 32'(v.exp_m1 && exp_err));
        check_output($sformatf("v%0d owner data", idx), v.exp_m1 ? m1_rdata : m0_rdata, exp_data);
        check_output($sformatf("v%0d other data", idx), v.exp_m1 ? m0_rdata : m1_rdata,
                     last_data[!v.exp_m1]);
        check_output($sformatf("v%0d select cycles", idx), 32'(hi), 32'(exp_hi));
        check_output($sformatf("v%0d select low in done", idx), 32'(s_sel), 32'd0);
        check_output($sformatf("v%0d s_addr stable", idx), 32'(stable), 32'd1);
        last_data[v.exp_m1] = exp_data;
        if (v.exp_m1) m1_sel = 1'b0;
        else          m0_sel = 1'b0;
    endtask

    task automatic fp_serve(input logic [31:0] exp_addr, input logic exp_m1, input logic [31:0] sdata);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = f_s_sel;
        end
        check_output("fp grant", 32'(got), 32'd1);
        check_output("fp s_addr", f_s_addr, exp_addr);
        f_s_ack = 1'b1;
        f_s_rdata = sdata;
        @(negedge clk);
        f_s_ack = 1'b0;
        check_output("fp m1_ack", 32'(f_m1_ack), 32'(exp_m1));
        check_output("fp m0_ack", 32'(f_m0_ack), 32'(!exp_m1));
        check_output("fp data", exp_m1 ? f_m1_rdata : f_m0_rdata, sdata);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic got;
        logic seen0;
        vec_t v;

        vecs[0] = '{1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 1'b1, 0, 32'h0000_0001, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 1'b1, 1, 32'h0000_0002, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 1'b1, 2, 32'h0000_0003, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 1'b1, 0, 32'h0000_0004, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 32'h010, 32'h000, 1'b0, 1'b0, 1, 32'h0000_ABCD, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 32'h000, 32'h044, 1'b0, 1'b0, -1, 32'h0000_FFFF, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 32'h020, 32'h000, 1'b1, 1'b0, 7, 32'h0000_7777, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 32'h000, 32'h048, 1'b0, 1'b0, 3, 32'h0000_1234, 1'b1};

        rst = 1'b0;
        m0_addr = '0; m0_wdata = '0; m0_sel = 1'b0; m0_we = 1'b0;
        m1_addr = '0; m1_wdata = '0; m1_sel = 1'b0; m1_we = 1'b0;
        s_ack = 1'b0; s_rdata = '0; f_s_ack = 1'b0; f_s_rdata = '0;
        last_data[0] = '0;
        last_data[1] = '0;
        repeat (2) @(negedge clk);
        check_output("reset s_sel", 32'(s_sel), 32'd0);
        check_output("reset s_addr", s_addr, 32'd0);
        check_output("reset acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
        check_output("reset m1_data", m1_rdata, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++)
            apply_stimulus(vecs[i], i);

        // Reset while a transaction is in flight, then a clean read afterwards.
        @(negedge clk);
        m0_sel = 1'b1; m0_addr = 32'h30; m0_we = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = s_sel;
        end
        check_output("midreset grant", 32'(got), 32'd1);
        rst = 1'b0;
        #1;
        check_output("midreset s_sel", 32'(s_sel), 32'd0);
        check_output("midreset s_addr", s_addr, 32'd0);
        check_output("midreset m0_data", m0_rdata, 32'd0);
        check_output("midreset m1_data", m1_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        m0_sel = 1'b0;
        last_data[0] = '0;
        last_data[1] = '0;
        v = '{1'b1, 1'b0, 32'h040, 32'h000, 1'b0, 1'b0, 0, 32'h0000_5A5A, 1'b0};
        apply_stimulus(v, 8);

        // m0 abandons its request mid-transaction; m1 is served next.
        @(negedge clk);
        m0_sel = 1'b1; m0_addr = 32'h50; m0_we = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = s_sel;
        end
        check_output("abort grant", s_addr, 32'h50);
        @(negedge clk);
        m0_sel = 1'b0;
        m1_sel = 1'b1; m1_addr = 32'h60; m1_we = 1'b0;
        seen0 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            s_ack = (i == 0);
            s_rdata = 32'h0000_BAD0;
            @(negedge clk);
            s_ack = 1'b0;
            if (m0_ack) seen0 = 1'b1;
            got = s_sel;
        end
        check_output("abort no m0_ack", 32'(seen0), 32'd0);
        check_output("abort m0_data held", m0_rdata, 32'h0000_5A5A);
        check_output("abort m1 granted", 32'(got), 32'd1);
        check_output("abort m1 s_addr", s_addr, 32'h60);
        s_ack = 1'b1;
        s_rdata = 32'h0000_6060;
        @(negedge clk);
        s_ack = 1'b0;
        check_output("abort m1_ack", 32'(m1_ack), 32'd1);
        check_output("abort m1_data", m1_rdata, 32'h0000_6060);
        m1_sel = 1'b0;

        // Fixed-priority instance: m1 keeps winning until it stops requesting.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        m0_sel = 1'b1; m0_addr = 32'h300; m0_we = 1'b0;
        m1_sel = 1'b1; m1_addr = 32'h400; m1_we = 1'b0;
        fp_serve(32'h400, 1'b1, 32'h0000_1111);
        fp_serve(32'h400, 1'b1, 32'h0000_2222);
        m1_sel = 1'b0;
        fp_serve(32'h300, 1'b0, 32'h0000_3333);
        m0_sel = 1'b0;

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
